// File: rtl/row_feeder_pkg.sv
// Shared encodings for the row feeder: FSM states and the instruction codes driven onto the row.
package row_feeder_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_GAP   = 3'd2,
        ST_EXEC  = 3'd3,
        ST_FLUSH = 3'd4,
        ST_DONE  = 3'd5
    } feeder_state_t;

    localparam logic [2:0] INST_NOP      = 3'b000;
    localparam logic [2:0] INST_WS_LOAD  = 3'b001;
    localparam logic [2:0] INST_WS_EXEC  = 3'b010;
    localparam logic [2:0] INST_OS_EXEC  = 3'b110;
    localparam logic [2:0] INST_OS_FLUSH = 3'b101;

    // A starved cycle keeps the dataflow bit so the tiles stay in the job's mode.
    function automatic logic [2:0] bubble_inst(input logic os);
        return {os, 2'b00};
    endfunction

endpackage

// File: rtl/feeder_fifo.sv
// Input word FIFO for the row feeder; extra pointer bit separates full from empty, no write-to-read bypass.
module feeder_fifo
    import row_feeder_pkg::*;
#(
    parameter int bw         = 4,
    parameter int fifo_depth = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [bw-1:0] wdata,
    input  logic          rd,
    output logic [bw-1:0] rdata,
    output logic          empty,
    output logic          full
);

    localparam int AW = $clog2(fifo_depth);

    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic [bw-1:0] mem_q [fifo_depth];
    logic          push;
    logic          pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign push  = wr && !full;
    assign pop   = rd && !empty;
    assign rdata = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/row_feeder.sv
// Sequences kernel-load / execute / flush words from the input FIFO into the first tile of a MAC row.
// Optional FEEDER_STALL_CNT_EN adds a saturating bubble counter on stall_cnt.
//
// state | meaning
// IDLE  | waiting for start; outputs idle
// LOAD  | WS: issue col kernel words (001), bubble when FIFO empty
// GAP   | WS: one quiet cycle between load and execute
// EXEC  | issue len activation words (010 WS / 110 OS), bubble when FIFO empty
// FLUSH | OS: col drain cycles (101) with zero data
// DONE  | one-cycle completion, pulses done
module row_feeder
    import row_feeder_pkg::*;
#(
    parameter int bw         = 4,
    parameter int col        = 8,
    parameter int fifo_depth = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          mode,
    input  logic          start,
    input  logic [7:0]    len,
    input  logic          wr,
    input  logic [bw-1:0] in_data,
    output logic          full,
    output logic [bw-1:0] out_e,
    output logic [2:0]    inst_e,
    output logic          busy,
    output logic          done
`ifdef FEEDER_STALL_CNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    localparam int CW = ($clog2(col + 1) > 8) ? $clog2(col + 1) : 8;

    feeder_state_t state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          mode_q, mode_d;
    logic [7:0]    len_q, len_d;
    logic [bw-1:0] out_q, out_d;
    logic [2:0]    inst_q, inst_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          pop;
    logic          bubble;
    logic [bw-1:0] fifo_rdata;
    logic          fifo_empty;

    feeder_fifo #(.bw(bw), .fifo_depth(fifo_depth)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .wr    (wr),
        .wdata (in_data),
        .rd    (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .full  (full)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        len_d   = len_q;
        out_d   = '0;
        inst_d  = INST_NOP;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        pop     = 1'b0;
        bubble  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mode_d = mode;
                    len_d  = len;
                    busy_d = 1'b1;
                    if (!mode) begin
                        state_d = ST_LOAD;
                        cnt_d   = CW'(col);
                    end else if (len == 8'd0) begin
                        state_d = ST_FLUSH;
                        cnt_d   = CW'(col);
                    end else begin
                        state_d = ST_EXEC;
                        cnt_d   = CW'(len);
                    end
                end
            end
            ST_LOAD: begin
                busy_d = 1'b1;
                if (fifo_empty) begin
                    bubble = 1'b1;
                end else begin
                    pop    = 1'b1;
                    out_d  = fifo_rdata;
                    inst_d = INST_WS_LOAD;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) state_d = ST_GAP;
                end
            end
            ST_GAP: begin
                busy_d = 1'b1;
                if (len_q == 8'd0) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_EXEC;
                    cnt_d   = CW'(len_q);
                end
            end
            ST_EXEC: begin
                busy_d = 1'b1;
                if (fifo_empty) begin
                    bubble = 1'b1;
                end else begin
                    pop    = 1'b1;
                    out_d  = fifo_rdata;
                    inst_d = mode_q ? INST_OS_EXEC : INST_WS_EXEC;
                    cnt_d  = cnt_q - CW'(1);
                    if (cnt_q == CW'(1)) begin
                        if (mode_q) begin
                            state_d = ST_FLUSH;
                            cnt_d   = CW'(col);
                        end else begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            ST_FLUSH: begin
                busy_d = 1'b1;
                inst_d = INST_OS_FLUSH;
                cnt_d  = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = ST_DONE;
            end
            ST_DONE: begin
                done_d  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (bubble) inst_d = bubble_inst(mode_q);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
            len_q   <= '0;
            out_q   <= '0;
            inst_q  <= INST_NOP;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            len_q   <= len_d;
            out_q   <= out_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_e  = out_q;
    assign inst_e = inst_q;
    assign busy   = busy_q;
    assign done   = done_q;

`ifdef FEEDER_STALL_CNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (state_q == ST_IDLE && start) begin
            stall_cnt_d = '0;
        end else if (bubble && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_row_feeder.sv
// Directed scoreboard bench for row_feeder: per-job expected output trace is queued, then compared cycle by cycle.
module tb_row_feeder;

    localparam int BW    = 8;
    localparam int COL   = 8;
    localparam int DEPTH = 16;

    localparam logic [2:0] I_NOP   = 3'b000;
    localparam logic [2:0] I_LOAD  = 3'b001;
    localparam logic [2:0] I_WSX   = 3'b010;
    localparam logic [2:0] I_OSX   = 3'b110;
    localparam logic [2:0] I_FLUSH = 3'b101;
    localparam logic [2:0] I_OSBUB = 3'b100;

    logic          clk = 1'b0;
    logic          reset;
    logic          mode;
    logic          start;
    logic [7:0]    len;
    logic          wr;
    logic [BW-1:0] in_data;
    logic          full;
    logic [BW-1:0] out_e;
    logic [2:0]    inst_e;
    logic          busy;
    logic          done;
`ifdef FEEDER_STALL_CNT_EN
    logic [15:0]   stall_cnt;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    int busy_seen;
    logic [BW+4:0] exp_q[$];

    row_feeder #(.bw(BW), .col(COL), .fifo_depth(DEPTH)) dut (
        .clk     (clk),
        .reset   (reset),
        .mode    (mode),
        .start   (start),
        .len     (len),
        .wr      (wr),
        .in_data (in_data),
        .full    (full),
        .out_e   (out_e),
        .inst_e  (inst_e),
        .busy    (busy),
        .done    (done)
`ifdef FEEDER_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] expv);
        n_tests++;
        assert (got === expv) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    function automatic void ex(input logic b, input logic d, input logic [2:0] i, input logic [BW-1:0] o);
        exp_q.push_back({b, d, i, o});
    endfunction

    function automatic void ex_words(input int n, input logic [2:0] i, input logic [BW-1:0] base);
        for (int w = 0; w < n; w++) ex(1'b1, 1'b0, i, base + BW'(w));
    endfunction

    function automatic void ex_rep(input int n, input logic [2:0] i);
        for (int w = 0; w < n; w++) ex(1'b1, 1'b0, i, '0);
    endfunction

    // Called and left at a falling edge; one word pushed per cycle.
    task automatic push_words(input int n, input logic [BW-1:0] base);
        for (int w = 0; w < n; w++) begin
            wr      = 1'b1;
            in_data = base + BW'(w);
            @(negedge clk);
        end
        wr = 1'b0;
    endtask

    // Issues start at the current falling edge, then compares ncyc output cycles against the queue.
    task automatic run_job(input string name, input logic m, input logic [7:0] l, input int ncyc,
                           input int push_at, input int npush, input logic [BW-1:0] pbase);
        logic [BW+4:0] got;
        logic [BW+4:0] expv;
        busy_seen = 0;
        start = 1'b1;
        mode  = m;
        len   = l;
        for (int k = 1; k <= ncyc; k++) begin
            @(negedge clk);
            start = 1'b0;
            got   = {busy, done, inst_e, out_e};
            if (busy) busy_seen++;
            expv = (exp_q.size() > 0) ? exp_q.pop_front() : {BW+5{1'b1}};
            check($sformatf("%s_c%0d", name, k), 32'(got), 32'(expv));
            if (k >= push_at && k < push_at + npush) begin
                wr      = 1'b1;
                in_data = pbase + BW'(k - push_at);
            end else begin
                wr = 1'b0;
            end
        end
        wr = 1'b0;
    endtask

    initial begin
        reset   = 1'b1;
        mode    = 1'b0;
        start   = 1'b0;
        len     = '0;
        wr      = 1'b0;
        in_data = '0;
        repeat (2) @(negedge clk);
        check("rst_outputs", 32'({busy, done, inst_e, out_e}), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // WS col=8 len=4 with 12 words ready
        push_words(12, 8'h00);
        ex_rep(1, I_NOP);
        ex_words(8, I_LOAD, 8'h00);
        ex_rep(1, I_NOP);
        ex_words(4, I_WSX, 8'h08);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("ws_basic", 1'b0, 8'd4, 16, 0, 0, '0);

        // OS len=3, busy for exactly 12 cycles
        push_words(3, 8'h20);
        ex_rep(1, I_NOP);
        ex_words(3, I_OSX, 8'h20);
        ex_rep(8, I_FLUSH);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("os_basic", 1'b1, 8'd3, 14, 0, 0, '0);
        check("os_busy_cycles", 32'(busy_seen), 32'd12);

        // WS with FIFO starving after word 9; word 10 arrives 3 cycles later
        push_words(10, 8'h30);
        ex_rep(1, I_NOP);
        ex_words(8, I_LOAD, 8'h30);
        ex_rep(1, I_NOP);
        ex_words(2, I_WSX, 8'h38);
        ex_rep(3, I_NOP);
        ex_words(2, I_WSX, 8'h3A);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("ws_stall", 1'b0, 8'd4, 19, 14, 2, 8'h3A);
`ifdef FEEDER_STALL_CNT_EN
        check("stall_ws", 32'(stall_cnt), 32'd3);
`endif

        // OS len=0 goes straight to flush
        ex_rep(1, I_NOP);
        ex_rep(8, I_FLUSH);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("os_len0", 1'b1, 8'd0, 11, 0, 0, '0);
`ifdef FEEDER_STALL_CNT_EN
        check("stall_cleared", 32'(stall_cnt), 32'd0);
`endif

        // Fill to 16, overflow push dropped, pop order 0..15
        push_words(15, 8'h40);
        check("full_at_15", 32'(full), 32'd0);
        push_words(1, 8'h4F);
        check("full_at_16", 32'(full), 32'd1);
        push_words(1, 8'hAA);
        check("full_after_drop", 32'(full), 32'd1);
        ex_rep(1, I_NOP);
        ex_words(8, I_LOAD, 8'h40);
        ex_rep(1, I_NOP);
        ex_words(8, I_WSX, 8'h48);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("ws_drain16", 1'b0, 8'd8, 20, 0, 0, '0);
        check("full_after_drain", 32'(full), 32'd0);
        // Dropped word must not surface: FIFO starts empty, so expect bubbles before 0x55
        ex_rep(1, I_NOP);
        ex_rep(2, I_OSBUB);
        ex_words(1, I_OSX, 8'h55);
        ex_rep(8, I_FLUSH);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("os_after_drop", 1'b1, 8'd1, 14, 2, 1, 8'h55);

        // Asynchronous reset in the middle of EXEC
        push_words(3, 8'h60);
        start = 1'b1;
        mode  = 1'b1;
        len   = 8'd3;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("mid_exec_word", 32'({busy, inst_e, out_e}), 32'({1'b1, I_OSX, 8'h60}));
        #2 reset = 1'b1;
        #1;
        check("async_rst_outputs", 32'({busy, done, inst_e, out_e}), 32'd0);
        check("async_rst_full", 32'(full), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        ex_rep(1, I_NOP);
        ex_rep(2, I_OSBUB);
        ex_words(1, I_OSX, 8'h77);
        ex_rep(8, I_FLUSH);
        ex(1'b0, 1'b1, I_NOP, '0);
        ex(1'b0, 1'b0, I_NOP, '0);
        run_job("post_reset", 1'b1, 8'd1, 14, 2, 1, 8'h77);
`ifdef FEEDER_STALL_CNT_EN
        check("stall_post_reset", 32'(stall_cnt), 32'd2);
`endif
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
